pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, meaning the payload width in bits (instruction, PC and PC+4 concatenated).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall-cycle counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1 bit: synchronous clear of all stored entries.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream stage presents in_data.
REQ-007 SHALL have port in_ready, output, 1 bit: this block accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, DATA_W bits: the upstream payload.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream stage consumes out_data this cycle.
REQ-011 SHALL have port out_data, output, DATA_W bits: the head entry.
REQ-012 SHALL have port occupancy, output, 2 bits: the number of stored entries (0, 1 or 2).
REQ-013 SHALL have port cnt_clr, input, 1 bit: synchronous clear of stall_cnt.
REQ-014 SHALL have port stall_cnt, output, CNT_W bits: the count of back-pressured cycles.

Function
REQ-015 SHALL define an input transfer ("in fire") as in_valid & in_ready, and an output transfer ("out fire") as out_valid & out_ready, both sampled at the rising clk edge.
REQ-016 SHALL hold a main register M and a skid register S, with a state machine over EMPTY, ONE and TWO.
REQ-017 SHALL drive out_data = M and out_valid = (state != EMPTY) directly from flops, with no combinational path from any input.
REQ-018 SHALL drive in_ready = (state != TWO) from state only, with no combinational path from out_ready.
REQ-019 SHALL, in EMPTY: on in fire, set M<=in_data and go to ONE; otherwise remain in EMPTY.
REQ-020 SHALL, in ONE:
  - on in fire & out fire, set M<=in_data and stay in ONE;
  - on in fire only, set S<=in_data and go to TWO;
  - on out fire only, go to EMPTY;
  - with neither, hold.
REQ-021 SHALL, in TWO: on out fire, set M<=S and go to ONE; otherwise hold, with in_valid ignored.
REQ-022 SHALL give one-cycle latency: data accepted at edge N appears on out_data after edge N, when accepted into an empty block.
REQ-023 SHALL deliver entries strictly in acceptance order, with no loss or duplication.
REQ-024 SHALL give flush the highest priority: at the edge, state<=EMPTY and M, S<=0.
REQ-025 SHALL discard any in fire and out fire coinciding with flush.
REQ-026 SHALL NOT have flush affect stall_cnt.
REQ-027 SHALL drive occupancy as 0, 1 or 2 for EMPTY, ONE or TWO respectively.
REQ-028 SHALL increment stall_cnt by 1 on each edge where out_valid & ~out_ready, and hold it otherwise.
REQ-029 SHALL saturate stall_cnt at 2^CNT_W-1, with no wrap-around.
REQ-030 SHALL make cnt_clr zero stall_cnt and take priority over a simultaneous increment.
REQ-031 SHALL leave S content don't-care outside TWO, while observable outputs depend only on M and state.

Reset
REQ-032 SHALL, on rst_n low and asynchronously, set state=EMPTY, M=0, S=0 and stall_cnt=0.
REQ-033 SHALL therefore force out_valid=0, out_data=0, occupancy=0 and in_ready=1 while rst_n is low.
REQ-034 SHALL drop in-flight entries on a reset asserted mid-operation, in any state.
REQ-035 SHALL resume normal operation at the first rising clk edge after rst_n deasserts.

Verification
REQ-036 SHALL cover single-entry passthrough: in_valid=1 with in_data=0xA, out_ready=1 -> out_valid=1 and out_data=0xA after one edge, occupancy=1.
REQ-037 SHALL cover the skid case: hold out_ready=0 and push 0xA then 0xB -> occupancy=2, in_ready=0; push 0xC while full -> ignored; raise out_ready -> outputs 0xA then 0xB, then EMPTY.
REQ-038 SHALL cover a streaming no-bubble run: in_valid=1 and out_ready=1 for 8 cycles with data 1..8 -> out_data 1..8 on consecutive cycles, occupancy constant at 1.
REQ-039 SHALL cover flush while full: state TWO, assert flush together with in_valid (0xD) -> next cycle occupancy=0, out_data=0, 0xD never emitted, and stall_cnt unchanged.
REQ-040 SHALL cover counter saturation and clear: CNT_W=4, 20 back-pressured cycles -> stall_cnt=15; cnt_clr on a stalled cycle -> stall_cnt=0.
REQ-041 SHALL cover asynchronous reset mid-stream: drop rst_n between clock edges in TWO -> out_valid=0, occupancy=0 and in_ready=1 immediately, before the next edge.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register (main M + skid S) with registered handshake outputs
// and a saturating counter of back-pressured cycles.
module pipe_skid_reg #(
    parameter int DATA_W = 96,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_fire, out_fire;

    // Handshake outputs come straight from state/M so no input reaches an output combinationally
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO);
    assign out_data  = m_q;
    assign occupancy = state_q;
    assign stall_cnt = cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            state_d = EMPTY;
            m_d     = '0;
            s_d     = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        m_d     = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_d = in_data;
                    end else if (in_fire) begin
                        s_d     = in_data;
                        state_d = TWO;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        m_d     = s_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Stall counter is independent of flush; clear beats increment, and it sticks at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed, table-driven bench for pipe_skid_reg (CNT_W=4 so saturation is reachable quickly).
module tb_pipe_skid_reg;

    localparam int DATA_W = 96;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;

    int n_compared;
    int n_failed;

    typedef struct {
        logic              iv;
        logic [DATA_W-1:0] d;
        logic              ordy;
        logic              fl;
        logic              clr;
        logic              e_ov;
        logic [DATA_W-1:0] e_data;
        logic [1:0]        e_occ;
        logic              e_ir;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic e_ov, input logic [DATA_W-1:0] e_data,
                               input logic [1:0] e_occ, input logic e_ir,
                               input logic [CNT_W-1:0] e_cnt);
        checkField({tag, ".out_valid"}, DATA_W'(out_valid), DATA_W'(e_ov));
        checkField({tag, ".out_data"},  out_data, e_data);
        checkField({tag, ".occupancy"}, DATA_W'(occupancy), DATA_W'(e_occ));
        checkField({tag, ".in_ready"},  DATA_W'(in_ready), DATA_W'(e_ir));
        checkField({tag, ".stall_cnt"}, DATA_W'(stall_cnt), DATA_W'(e_cnt));
    endtask

    // Drive at the falling edge, let one rising edge pass, sample 1ns later
    task automatic applyStimulus(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                                 input logic fl, input logic clr);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                          input logic fl, input logic clr, input logic e_ov,
                          input logic [DATA_W-1:0] e_data, input logic [1:0] e_occ,
                          input logic e_ir, input logic [CNT_W-1:0] e_cnt);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.clr = clr;
        v.e_ov = e_ov; v.e_data = e_data; v.e_occ = e_occ; v.e_ir = e_ir; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    initial begin
        n_compared = 0;
        n_failed   = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        cnt_clr    = 1'b0;

        // Passthrough
        addVec(1, 'hA, 1, 0, 0,   1, 'hA, 1, 1, 0);
        addVec(0, 'h0, 1, 0, 0,   0, 'hA, 0, 1, 0);
        // Skid: A, B with back-pressure, C ignored while full, then drain
        addVec(1, 'hA, 0, 0, 0,   1, 'hA, 1, 1, 0);
        addVec(1, 'hB, 0, 0, 0,   1, 'hA, 2, 0, 1);
        addVec(1, 'hC, 0, 0, 0,   1, 'hA, 2, 0, 2);
        addVec(0, 'h0, 1, 0, 0,   1, 'hB, 1, 1, 2);
        addVec(0, 'h0, 1, 0, 0,   0, 'hB, 0, 1, 2);
        // Streaming 1..8 with no bubbles
        for (int k = 1; k <= 8; k++) begin
            addVec(1, DATA_W'(k), 1, 0, 0,   1, DATA_W'(k), 1, 1, 2);
        end
        addVec(0, 'h0, 1, 0, 0,   0, 'h8, 0, 1, 2);
        // Counter clear while idle
        addVec(0, 'h0, 0, 0, 1,   0, 'h8, 0, 1, 0);
        // Fill to TWO, then flush together with in_valid=0xD
        addVec(1, 'h1, 0, 0, 0,   1, 'h1, 1, 1, 0);
        addVec(1, 'h2, 0, 0, 0,   1, 'h1, 2, 0, 1);
        addVec(1, 'hD, 1, 1, 0,   0, 'h0, 0, 1, 1);
        addVec(0, 'h0, 1, 0, 0,   0, 'h0, 0, 1, 1);
        addVec(0, 'h0, 1, 0, 0,   0, 'h0, 0, 1, 1);

        #12;
        checkOutput("reset_held", 0, '0, 0, 1, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_data,
                        vecs[i].e_occ, vecs[i].e_ir, vecs[i].e_cnt);
        end

        // Saturation: one entry held under back-pressure for 20 cycles from cnt=1
        applyStimulus(1, 'h5, 0, 0, 0);
        checkOutput("sat_load", 1, 'h5, 1, 1, 1);
        for (int k = 0; k < 20; k++) applyStimulus(0, 'h0, 0, 0, 0);
        checkOutput("sat_15", 1, 'h5, 1, 1, 15);
        applyStimulus(0, 'h0, 0, 0, 1);
        checkOutput("clr_on_stall", 1, 'h5, 1, 1, 0);
        applyStimulus(0, 'h0, 0, 0, 0);
        checkOutput("incr_after_clr", 1, 'h5, 1, 1, 1);

        // Asynchronous reset in TWO, between edges
        applyStimulus(1, 'h6, 0, 0, 0);
        checkOutput("two_before_rst", 1, 'h5, 2, 0, 2);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst", 0, '0, 0, 1, 0);
        @(posedge clk);
        #1;
        checkOutput("rst_still_low", 0, '0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 'h7, 1, 0, 0);
        checkOutput("resume", 1, 'h7, 1, 1, 0);
        applyStimulus(0, 'h0, 1, 0, 0);
        checkOutput("resume_drain", 0, 'h7, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
